// File: rtl/float_pkg.sv
// float_pkg: shared types and the packing function for the FP add/sub back end.
//
// Contents:
//   N_DEF / EXP_DEF   default mantissa (incl. hidden bit) and exponent widths
//   QNAN_FRAC_DEF     canonical quiet-NaN fraction for the default format
//   pack_case_t       which packing rule applies to a rounded result
//   pack_case()       priority classification of a rounded result
//   pack_word()       assembles {sign, exp, frac} for any N/EXP (N <= 64, EXP <= 32)
//
// Build option: FLOAT_PACK_FTZ_EN -- when defined, subnormal normal-path results
// (exponent 0, mantissa non-zero) are flushed to a signed zero.
package float_pkg;

  localparam int N_DEF   = 24;
  localparam int EXP_DEF = 8;

  localparam logic [N_DEF-2:0] QNAN_FRAC_DEF = 23'h400000;

  typedef enum logic [2:0] {
    PK_NAN   = 3'd0,
    PK_INF   = 3'd1,
    PK_ZERO  = 3'd2,
    PK_CARRY = 3'd3,
    PK_NORM  = 3'd4
  } pack_case_t;

  // NaN beats Inf beats Zero; a zero mantissa with a non-zero exponent means the
  // round-up carried out of the mantissa and the hidden bit was lost.
  function automatic pack_case_t pack_case(input logic nan,
                                           input logic inf,
                                           input logic zero,
                                           input logic mant_zero,
                                           input logic exp_zero);
    pack_case_t pc;
    if (nan) begin
      pc = PK_NAN;
    end else if (inf) begin
      pc = PK_INF;
    end else if (zero) begin
      pc = PK_ZERO;
    end else if (mant_zero && !exp_zero) begin
      pc = PK_CARRY;
    end else begin
      pc = PK_NORM;
    end
    return pc;
  endfunction

  // Width-generic packer: fields are built in a 96-bit scratch word and the
  // caller keeps the low n+e bits. n and e are elaboration constants at every
  // call site, so all shifts collapse to wiring.
  function automatic logic [95:0] pack_word(input pack_case_t pc,
                                            input logic sign,
                                            input logic [31:0] exp_in,
                                            input logic [63:0] mant_in,
                                            input int n,
                                            input int e);
    logic [95:0] exp_ones;
    logic [95:0] frac_mask;
    logic [95:0] qnan_frac;
    logic [95:0] exp_f;
    logic [95:0] frac_f;
    exp_ones  = (96'd1 << e) - 96'd1;
    frac_mask = (96'd1 << (n - 1)) - 96'd1;
    qnan_frac = 96'd1 << (n - 2);
    case (pc)
      PK_NAN: begin
        exp_f  = exp_ones;
        frac_f = qnan_frac;
      end
      PK_INF: begin
        exp_f  = exp_ones;
        frac_f = 96'd0;
      end
      PK_ZERO: begin
        exp_f  = 96'd0;
        frac_f = 96'd0;
      end
      PK_CARRY: begin
        // exp+1 reaching all-ones is exactly the infinity encoding, so the
        // saturating case needs no separate value here.
        exp_f  = ({64'd0, exp_in} + 96'd1) & exp_ones;
        frac_f = 96'd0;
      end
      PK_NORM: begin
        exp_f = {64'd0, exp_in} & exp_ones;
`ifdef FLOAT_PACK_FTZ_EN
        if (exp_in == 32'd0) begin
          frac_f = 96'd0;
        end else begin
          frac_f = {32'd0, mant_in} & frac_mask;
        end
`else
        frac_f = {32'd0, mant_in} & frac_mask;
`endif
      end
      default: begin
        exp_f  = 96'd0;
        frac_f = 96'd0;
      end
    endcase
    return ({95'd0, sign} << (n - 1 + e)) | (exp_f << (n - 1)) | frac_f;
  endfunction

endpackage

// File: rtl/float_pack_fifo.sv
// float_pack_fifo: small synchronous FIFO with registered storage and no bypass.
//
// Ports:
//   Clock, Reset  clock and synchronous active-high reset (empties the FIFO,
//                 clears storage and the sticky drop flag)
//   push, data_in write request and data; ignored (and flagged) when full
//                 unless a pop happens in the same cycle
//   pop           read request; ignored when empty
//   data_out      head entry (storage read, valid while !empty)
//   full, empty   occupancy status
//   dropped       sticky: a push was discarded because the FIFO was full
module float_pack_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic             dropped
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             dropped_q, dropped_d;
  logic             do_push_s;
  logic             do_pop_s;

  assign full     = (count_q == CNT_FULL);
  assign empty    = (count_q == {(AW+1){1'b0}});
  assign data_out = mem_q[rd_ptr_q];
  assign dropped  = dropped_q;

  // Next-state: a pop frees a slot, so a full FIFO still accepts a push in the
  // same cycle; the write lands in the slot being vacated.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    do_pop_s  = pop && !empty;
    do_push_s = push && (!full || do_pop_s);
    dropped_d = dropped_q | (push && full && !do_pop_s);
    if (do_push_s) begin
      mem_d[wr_ptr_q] = data_in;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // State registers; storage is cleared too so the head reads zero after reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q  <= {AW{1'b0}};
      rd_ptr_q  <= {AW{1'b0}};
      count_q   <= {(AW+1){1'b0}};
      dropped_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      dropped_q <= dropped_d;
    end
  end

endmodule

// File: rtl/float_pack.sv
// float_pack: back end of the FP add/sub pipeline. Resolves specials and the
// round-up carry-out, packs {sign, exp, frac} and buffers results in a FIFO
// with a valid/ready output, since the rounding stage cannot be stalled.
//
// Ports:
//   Clock, Reset       clock, synchronous active-high reset
//   inValid            rounding-stage result valid (pushes into the FIFO)
//   roundMant          rounded mantissa, bit N-1 is the hidden bit
//   roundExp           biased exponent
//   roundSign          result sign
//   isInf/isNaN/isZero special-case flags aligned with inValid
//   outReady           downstream ready
//   outValid           FIFO non-empty; result holds the head entry
//   result             packed word {sign, exp[EXP-1:0], frac[N-2:0]}
//   expOvf             sticky: a carry pushed the exponent to infinity
//   dropped            sticky: a push was lost because the FIFO was full
//   resultCount        wrapping count of popped results
//
// Build option: FLOAT_PACK_FTZ_EN flushes subnormal normal-path results to zero.
module float_pack
  import float_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int EXP   = EXP_DEF,
  parameter int DEPTH = 2
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             inValid,
  input  logic [N-1:0]     roundMant,
  input  logic [EXP-1:0]   roundExp,
  input  logic             roundSign,
  input  logic             isInf,
  input  logic             isNaN,
  input  logic             isZero,
  input  logic             outReady,
  output logic             outValid,
  output logic [N+EXP-1:0] result,
  output logic             expOvf,
  output logic             dropped,
  output logic [15:0]      resultCount
);

  localparam int W = N + EXP;

  pack_case_t     pc_s;
  logic [95:0]    word_s;
  logic [W-1:0]   packed_s;
  logic [EXP-1:0] exp_inc_s;
  logic           sat_s;
  logic           fifo_empty_s;
  logic           fifo_full_unused_s;
  logic           word_hi_unused_s;

  logic           expOvf_q, expOvf_d;
  logic [15:0]    resultCount_q, resultCount_d;

  // Classify and pack the incoming rounded result.
  always_comb begin
    pc_s      = pack_case(isNaN, isInf, isZero,
                          roundMant == {N{1'b0}}, roundExp == {EXP{1'b0}});
    word_s    = pack_word(pc_s, roundSign, 32'(roundExp), 64'(roundMant), N, EXP);
    packed_s  = word_s[W-1:0];
    exp_inc_s = roundExp + {{(EXP-1){1'b0}}, 1'b1};
    sat_s     = (pc_s == PK_CARRY) && (exp_inc_s == {EXP{1'b1}});
  end

  assign word_hi_unused_s = ^word_s[95:W];

  float_pack_fifo #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .Clock    (Clock),
    .Reset    (Reset),
    .push     (inValid),
    .data_in  (packed_s),
    .pop      (outReady),
    .data_out (result),
    .full     (fifo_full_unused_s),
    .empty    (fifo_empty_s),
    .dropped  (dropped)
  );

  assign outValid    = !fifo_empty_s;
  assign expOvf      = expOvf_q;
  assign resultCount = resultCount_q;

  // Sticky overflow flag and popped-result counter (wraps naturally at 16 bits).
  always_comb begin
    expOvf_d = expOvf_q | (inValid & sat_s);
    if (outValid && outReady) begin
      resultCount_d = resultCount_q + 16'd1;
    end else begin
      resultCount_d = resultCount_q;
    end
  end

  // Status registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      expOvf_q      <= 1'b0;
      resultCount_q <= 16'd0;
    end else begin
      expOvf_q      <= expOvf_d;
      resultCount_q <= resultCount_d;
    end
  end

endmodule

// File: tb/tb_float_pack.sv
// Directed self-checking bench for float_pack (default N=24, EXP=8, DEPTH=2).
module tb_float_pack;

  logic        Clock;
  logic        Reset;
  logic        inValid;
  logic [23:0] roundMant;
  logic [7:0]  roundExp;
  logic        roundSign;
  logic        isInf;
  logic        isNaN;
  logic        isZero;
  logic        outReady;
  logic        outValid;
  logic [31:0] result;
  logic        expOvf;
  logic        dropped;
  logic [15:0] resultCount;

  int pass_cnt  = 0;
  int total_cnt = 0;

  float_pack dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .inValid     (inValid),
    .roundMant   (roundMant),
    .roundExp    (roundExp),
    .roundSign   (roundSign),
    .isInf       (isInf),
    .isNaN       (isNaN),
    .isZero      (isZero),
    .outReady    (outReady),
    .outValid    (outValid),
    .result      (result),
    .expOvf      (expOvf),
    .dropped     (dropped),
    .resultCount (resultCount)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Present one input for one posedge; returns at the following negedge with inValid still set.
  task automatic drive(input logic [23:0] m, input logic [7:0] e, input logic s,
                       input logic nan, input logic inf, input logic zero);
    inValid   = 1'b1;
    roundMant = m;
    roundExp  = e;
    roundSign = s;
    isNaN     = nan;
    isInf     = inf;
    isZero    = zero;
    @(negedge Clock);
  endtask

  task automatic idle_in();
    inValid = 1'b0;
    isNaN   = 1'b0;
    isInf   = 1'b0;
    isZero  = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    idle_in();
    outReady = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    total_cnt++;
    if (outValid !== 1'b0) $display("FAIL reset_outValid got %0b want 0", outValid);
    else pass_cnt++;
    total_cnt++;
    if (result !== 32'h0) $display("FAIL reset_result got %h want 00000000", result);
    else pass_cnt++;
    total_cnt++;
    if ({expOvf, dropped} !== 2'b00) $display("FAIL reset_flags got %b want 00", {expOvf, dropped});
    else pass_cnt++;
    total_cnt++;
    if (resultCount !== 16'd0) $display("FAIL reset_count got %0d want 0", resultCount);
    else pass_cnt++;
  endtask

  task automatic test_normal();
    outReady = 1'b1;
    drive(24'hC00000, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_in();
    total_cnt++;
    if (outValid !== 1'b1 || result !== 32'h40400000)
      $display("FAIL normal got v=%0b %h want v=1 40400000", outValid, result);
    else pass_cnt++;
    @(negedge Clock);
    total_cnt++;
    if (outValid !== 1'b0) $display("FAIL normal_one_cycle got v=%0b want 0", outValid);
    else pass_cnt++;
    total_cnt++;
    if (resultCount !== 16'd1) $display("FAIL normal_count got %0d want 1", resultCount);
    else pass_cnt++;
  endtask

  task automatic test_carry();
    outReady = 1'b1;
    drive(24'h000000, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_in();
    total_cnt++;
    if (result !== 32'h40000000 || expOvf !== 1'b0)
      $display("FAIL carry_7F got %h ovf=%0b want 40000000 ovf=0", result, expOvf);
    else pass_cnt++;
    drive(24'h000000, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_in();
    total_cnt++;
    if (result !== 32'h7F800000 || outValid !== 1'b1)
      $display("FAIL carry_FE got %h v=%0b want 7f800000 v=1", result, outValid);
    else pass_cnt++;
    total_cnt++;
    if (expOvf !== 1'b1) $display("FAIL carry_expOvf got %0b want 1", expOvf);
    else pass_cnt++;
    @(negedge Clock);
  endtask

  task automatic test_specials();
    outReady = 1'b1;
    drive(24'h123456, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0);
    idle_in();
    total_cnt++;
    if (result !== 32'hFFC00000) $display("FAIL spec_nan got %h want ffc00000", result);
    else pass_cnt++;
    drive(24'h123456, 8'h55, 1'b1, 1'b0, 1'b1, 1'b0);
    idle_in();
    total_cnt++;
    if (result !== 32'hFF800000) $display("FAIL spec_inf got %h want ff800000", result);
    else pass_cnt++;
    drive(24'h123456, 8'h55, 1'b1, 1'b0, 1'b0, 1'b1);
    idle_in();
    total_cnt++;
    if (result !== 32'h80000000) $display("FAIL spec_zero got %h want 80000000", result);
    else pass_cnt++;
    drive(24'h123456, 8'h55, 1'b1, 1'b1, 1'b1, 1'b0);
    idle_in();
    total_cnt++;
    if (result !== 32'hFFC00000) $display("FAIL spec_nan_over_inf got %h want ffc00000", result);
    else pass_cnt++;
    @(negedge Clock);
    total_cnt++;
    if (resultCount !== 16'd7 || outValid !== 1'b0)
      $display("FAIL spec_count got %0d v=%0b want 7 v=0", resultCount, outValid);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    outReady = 1'b0;
    drive(24'hC00000, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(24'hA00000, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(24'h800000, 8'h82, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_in();
    total_cnt++;
    if (dropped !== 1'b1) $display("FAIL bp_dropped got %0b want 1", dropped);
    else pass_cnt++;
    total_cnt++;
    if (outValid !== 1'b1 || result !== 32'h40400000)
      $display("FAIL bp_head_A got v=%0b %h want v=1 40400000", outValid, result);
    else pass_cnt++;
    outReady = 1'b1;
    @(negedge Clock);
    total_cnt++;
    if (outValid !== 1'b1 || result !== 32'h40A00000)
      $display("FAIL bp_head_B got v=%0b %h want v=1 40a00000", outValid, result);
    else pass_cnt++;
    @(negedge Clock);
    total_cnt++;
    if (outValid !== 1'b0 || resultCount !== 16'd9)
      $display("FAIL bp_drain got v=%0b cnt=%0d want v=0 cnt=9", outValid, resultCount);
    else pass_cnt++;
  endtask

  task automatic test_full_push_pop();
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    outReady = 1'b0;
    drive(24'hC00000, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(24'hA00000, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0);
    outReady = 1'b1;
    drive(24'h800000, 8'h82, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_in();
    total_cnt++;
    if (dropped !== 1'b0) $display("FAIL fpp_dropped got %0b want 0", dropped);
    else pass_cnt++;
    total_cnt++;
    if (outValid !== 1'b1 || result !== 32'h40A00000)
      $display("FAIL fpp_head_Q got v=%0b %h want v=1 40a00000", outValid, result);
    else pass_cnt++;
    @(negedge Clock);
    total_cnt++;
    if (outValid !== 1'b1 || result !== 32'h41000000)
      $display("FAIL fpp_head_D got v=%0b %h want v=1 41000000", outValid, result);
    else pass_cnt++;
    @(negedge Clock);
    total_cnt++;
    if (outValid !== 1'b0 || resultCount !== 16'd3)
      $display("FAIL fpp_drain got v=%0b cnt=%0d want v=0 cnt=3", outValid, resultCount);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    outReady = 1'b0;
    drive(24'h000000, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(24'hC00000, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(24'hA00000, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_in();
    total_cnt++;
    if ({outValid, expOvf, dropped} !== 3'b111)
      $display("FAIL rmid_pre got %b want 111", {outValid, expOvf, dropped});
    else pass_cnt++;
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    total_cnt++;
    if ({outValid, expOvf, dropped} !== 3'b000 || resultCount !== 16'd0 || result !== 32'h0)
      $display("FAIL rmid_cleared got v/ovf/drop=%b cnt=%0d res=%h want 000 0 00000000",
               {outValid, expOvf, dropped}, resultCount, result);
    else pass_cnt++;
    drive(24'h800000, 8'h82, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_in();
    total_cnt++;
    if (outValid !== 1'b1 || result !== 32'hC1000000)
      $display("FAIL rmid_post_push got v=%0b %h want v=1 c1000000", outValid, result);
    else pass_cnt++;
    outReady = 1'b1;
    @(negedge Clock);
  endtask

  task automatic test_subnormal();
    logic [31:0] exp_sub;
`ifdef FLOAT_PACK_FTZ_EN
    exp_sub = 32'h00000000;
`else
    exp_sub = 32'h00000001;
`endif
    outReady = 1'b1;
    drive(24'h000001, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_in();
    total_cnt++;
    if (outValid !== 1'b1 || result !== exp_sub)
      $display("FAIL subnormal got v=%0b %h want v=1 %h", outValid, result, exp_sub);
    else pass_cnt++;
    @(negedge Clock);
  endtask

  initial begin
    Reset     = 1'b1;
    inValid   = 1'b0;
    roundMant = 24'h0;
    roundExp  = 8'h0;
    roundSign = 1'b0;
    isInf     = 1'b0;
    isNaN     = 1'b0;
    isZero    = 1'b0;
    outReady  = 1'b0;
    test_reset();
    test_normal();
    test_carry();
    test_specials();
    test_backpressure();
    test_full_push_pop();
    test_reset_mid();
    test_subnormal();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
